// File: rtl/cpu_pkg.sv
// Shared definitions for the control unit: sizes, instruction field positions,
// opcode values and the FSM state encoding.
package cpu_pkg;
  localparam int WIDTH   = 8;
  localparam int NREG    = 8;
  localparam int REG_AW  = 3;
  localparam int INSTR_W = 9;

  localparam int OP_HI = 8;
  localparam int OP_LO = 6;
  localparam int RX_HI = 5;
  localparam int RX_LO = 3;
  localparam int RY_HI = 2;
  localparam int RY_LO = 0;

  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_ADD  = 3'b001,
    OP_MVI  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_NOP  = 3'b110,
    OP_HALT = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  function automatic logic writes_reg(input opcode_e op);
    return (op != OP_NOP) && (op != OP_HALT);
  endfunction
endpackage

// File: rtl/reg_file.sv
// General register file: one write port with one-hot enable, two operand read
// ports and a debug read port, all reads combinational.
module reg_file #(
  parameter int WIDTH = cpu_pkg::WIDTH,
  parameter int NREG  = cpu_pkg::NREG,
  parameter int AW    = cpu_pkg::REG_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREG-1:0]  we,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    ra_addr,
  input  logic [AW-1:0]    rb_addr,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] ra_data,
  output logic [WIDTH-1:0] rb_data,
  output logic [WIDTH-1:0] dbg_data
);
  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = we[i] ? wdata : regs_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign ra_data  = regs_q[ra_addr];
  assign rb_data  = regs_q[rb_addr];
  assign dbg_data = regs_q[dbg_addr];
endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: IDLE/FETCH/DECODE/EXEC/WB/HALT sequencer driving an
// external ALU and the local register file. All outputs are registered.
module control_unit #(
  parameter int WIDTH = cpu_pkg::WIDTH,
  parameter int NREG  = cpu_pkg::NREG
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        run,
  input  logic [cpu_pkg::INSTR_W-1:0] instruction,
  input  logic [15:0]                 data_var,
  input  logic [WIDTH-1:0]            alu_result,
  output logic                        step,
  output logic [WIDTH-1:0]            alu_a,
  output logic [WIDTH-1:0]            alu_b,
  output logic [cpu_pkg::INSTR_W-1:0] alu_instr,
  output logic [NREG-1:0]             reg_wr,
  input  logic [cpu_pkg::REG_AW-1:0]  rd_sel,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        done,
  output logic                        halted,
  output logic [2:0]                  state_dbg
);
  import cpu_pkg::*;

  state_e              state_q, state_d;
  logic [INSTR_W-1:0]  ir_q, ir_d, alu_instr_q, alu_instr_d;
  logic [WIDTH-1:0]    imm_q, imm_d, g_q, g_d;
  logic [WIDTH-1:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic                step_q, step_d, done_q, done_d, halted_q, halted_d;
  logic [NREG-1:0]     reg_wr_q, reg_wr_d;

  logic [INSTR_W-1:0]  cur_instr;
  opcode_e             cur_op;
  logic [REG_AW-1:0]   cur_rx, cur_ry;
  logic [WIDTH-1:0]    rd_a, rd_b, wdata;
  logic                unused_data_hi;

  assign unused_data_hi = ^data_var[15:WIDTH];

  // During DECODE the fields come straight off the ROM; afterwards from IR.
  always_comb begin
    cur_instr = (state_q == S_DECODE) ? instruction : ir_q;
    cur_op    = opcode_e'(cur_instr[OP_HI:OP_LO]);
    cur_rx    = cur_instr[RX_HI:RX_LO];
    cur_ry    = cur_instr[RY_HI:RY_LO];
  end

  always_comb begin
    case (opcode_e'(ir_q[OP_HI:OP_LO]))
      OP_MV:   wdata = rd_b;
      OP_MVI:  wdata = imm_q;
      default: wdata = g_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    imm_d       = imm_q;
    g_d         = g_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_instr_d = alu_instr_q;
    step_d      = 1'b0;
    done_d      = 1'b0;
    reg_wr_d    = '0;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        ir_d  = instruction;
        imm_d = data_var[WIDTH-1:0];
        case (cur_op)
          OP_HALT:              state_d = S_HALT;
          OP_MV, OP_MVI, OP_NOP: state_d = S_WB;
          default:              state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        g_d     = alu_result;
        state_d = S_WB;
      end
      S_WB:     state_d = run ? S_FETCH : S_IDLE;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
    // Operands are loaded on the way into EXEC so they are stable for the whole cycle.
    if (state_d == S_EXEC) begin
      alu_a_d     = rd_a;
      alu_b_d     = rd_b;
      alu_instr_d = cur_instr;
    end
    if (state_d == S_WB) begin
      step_d = 1'b1;
      done_d = 1'b1;
      if (writes_reg(cur_op)) reg_wr_d[cur_rx] = 1'b1;
    end
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      imm_q       <= '0;
      g_q         <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_instr_q <= '0;
      step_q      <= 1'b0;
      done_q      <= 1'b0;
      halted_q    <= 1'b0;
      reg_wr_q    <= '0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      imm_q       <= imm_d;
      g_q         <= g_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_instr_q <= alu_instr_d;
      step_q      <= step_d;
      done_q      <= done_d;
      halted_q    <= halted_d;
      reg_wr_q    <= reg_wr_d;
    end
  end

  // The write lands on the edge that ends WB, so rd_data shows the old value during WB.
  reg_file #(.WIDTH(WIDTH), .NREG(NREG), .AW(REG_AW)) u_regs (
    .clk      (clk),
    .rst      (rst),
    .we       (reg_wr_q),
    .wdata    (wdata),
    .ra_addr  (cur_rx),
    .rb_addr  (cur_ry),
    .dbg_addr (rd_sel),
    .ra_data  (rd_a),
    .rb_data  (rd_b),
    .dbg_data (rd_data)
  );

  assign step      = step_q;
  assign done      = done_q;
  assign halted    = halted_q;
  assign reg_wr    = reg_wr_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_instr = alu_instr_q;
  assign state_dbg = state_q;
endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit: a behavioural ALU feeds alu_result and
// each task checks one feature against hand-computed values.
module tb_control_unit;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [8:0] instruction;
  logic [15:0] data_var;
  logic [7:0] alu_result;
  logic       step, done, halted;
  logic [7:0] alu_a, alu_b, rd_data, reg_wr;
  logic [8:0] alu_instr;
  logic [2:0] rd_sel, state_dbg;

  int checks = 0;
  int errors = 0;

  control_unit #(.WIDTH(8), .NREG(8)) dut (
    .clk(clk), .rst(rst), .run(run), .instruction(instruction), .data_var(data_var),
    .alu_result(alu_result), .step(step), .alu_a(alu_a), .alu_b(alu_b),
    .alu_instr(alu_instr), .reg_wr(reg_wr), .rd_sel(rd_sel), .rd_data(rd_data),
    .done(done), .halted(halted), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_instr[8:6])
      3'b001:  alu_result = alu_a + alu_b;
      3'b011:  alu_result = alu_a - alu_b;
      3'b100:  alu_result = alu_a & alu_b;
      3'b101:  alu_result = alu_a | alu_b;
      default: alu_result = 8'h00;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input logic [2:0] idx, output logic [7:0] val);
    rd_sel = idx;
    #1;
    val = rd_data;
  endtask

  // Issues one instruction with run dropped after FETCH, so the block returns to IDLE.
  task automatic run_instr(input logic [8:0] ins, input logic [15:0] dv,
                           output int ncyc, output int nstep, output int ndone,
                           output logic [7:0] wr_seen, output logic [7:0] ea,
                           output logic [7:0] eb, output logic [7:0] wb_rd);
    instruction = ins;
    data_var    = dv;
    rd_sel      = ins[5:3];
    run         = 1'b1;
    tick();
    run = 1'b0;
    ncyc = 0; nstep = 0; ndone = 0; wr_seen = '0; ea = '0; eb = '0; wb_rd = '0;
    while (state_dbg != S_IDLE && ncyc < 40) begin
      ncyc++;
      if (step) nstep++;
      if (done) ndone++;
      wr_seen |= reg_wr;
      if (state_dbg == S_EXEC) begin ea = alu_a; eb = alu_b; end
      if (state_dbg == S_WB) wb_rd = rd_data;
      tick();
    end
  endtask

  task automatic exec_simple(input logic [8:0] ins, input logic [15:0] dv, input string name);
    int nc, ns, nd;
    logic [7:0] w, a, b, p;
    run_instr(ins, dv, nc, ns, nd, w, a, b, p);
    checks++;
    if (state_dbg != S_IDLE) begin
      errors++;
      $display("FAIL %s timeout state=%0d required=%0d", name, state_dbg, S_IDLE);
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b0; run = 1'b0; instruction = '0; data_var = '0; rd_sel = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({step, done, halted, reg_wr, alu_a, alu_b, alu_instr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %0h required 0",
               {step, done, halted, reg_wr, alu_a, alu_b, alu_instr});
    end
    checks++;
    if (state_dbg !== S_IDLE) begin
      errors++; $display("FAIL reset_state got %0d required %0d", state_dbg, S_IDLE);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (state_dbg !== S_IDLE) begin
      errors++; $display("FAIL idle_hold got %0d required %0d", state_dbg, S_IDLE);
    end
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), v);
      checks++;
      if (v !== 8'h00) begin
        errors++; $display("FAIL reset_reg R%0d got %0h required 0", i, v);
      end
    end
  endtask

  task automatic test_mvi();
    int nc, ns, nd;
    logic [7:0] w, a, b, p, v;
    run_instr(9'b010_000_000, 16'h0005, nc, ns, nd, w, a, b, p);
    checks++;
    if (nc !== 3) begin errors++; $display("FAIL mvi_cycles got %0d required 3", nc); end
    checks++;
    if (ns !== 1 || nd !== 1) begin
      errors++; $display("FAIL mvi_pulses got step=%0d done=%0d required 1/1", ns, nd);
    end
    checks++;
    if (w !== 8'b0000_0001) begin errors++; $display("FAIL mvi_reg_wr got %b required 00000001", w); end
    checks++;
    if (p !== 8'h00) begin errors++; $display("FAIL mvi_wb_prewrite got %0h required 0", p); end
    read_reg(3'd0, v);
    checks++;
    if (v !== 8'h05) begin errors++; $display("FAIL mvi_r0 got %0h required 5", v); end
  endtask

  task automatic test_add();
    int nc, ns, nd;
    logic [7:0] w, a, b, p, v;
    exec_simple(9'b010_001_000, 16'h0008, "mvi_r1");
    run_instr(9'b001_000_001, 16'h0000, nc, ns, nd, w, a, b, p);
    checks++;
    if (a !== 8'h05 || b !== 8'h08) begin
      errors++; $display("FAIL add_operands got a=%0h b=%0h required 5/8", a, b);
    end
    checks++;
    if (nc !== 4) begin errors++; $display("FAIL add_cycles got %0d required 4", nc); end
    read_reg(3'd0, v);
    checks++;
    if (v !== 8'h0D) begin errors++; $display("FAIL add_r0 got %0h required 0d", v); end
    checks++;
    if (alu_instr !== 9'b001_000_001) begin
      errors++; $display("FAIL alu_instr_hold got %b required 001000001", alu_instr);
    end
  endtask

  task automatic test_wrap();
    int nc, ns, nd;
    logic [7:0] w, a, b, p, v;
    exec_simple(9'b010_010_000, 16'h12FF, "mvi_r2");
    exec_simple(9'b010_011_000, 16'h0001, "mvi_r3");
    run_instr(9'b001_010_011, 16'h0000, nc, ns, nd, w, a, b, p);
    read_reg(3'd2, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL add_wrap got %0h required 0", v); end
    checks++;
    if (nd !== 1) begin errors++; $display("FAIL add_wrap_done got %0d required 1", nd); end
    exec_simple(9'b011_010_011, 16'h0000, "sub_r2");
    read_reg(3'd2, v);
    checks++;
    if (v !== 8'hFF) begin errors++; $display("FAIL sub_wrap got %0h required ff", v); end
  endtask

  task automatic test_logic();
    logic [7:0] v;
    exec_simple(9'b010_110_000, 16'h003C, "mvi_r6");
    exec_simple(9'b010_111_000, 16'h000F, "mvi_r7");
    exec_simple(9'b100_110_111, 16'h0000, "and_r6");
    read_reg(3'd6, v);
    checks++;
    if (v !== 8'h0C) begin errors++; $display("FAIL and_r6 got %0h required 0c", v); end
    exec_simple(9'b101_001_111, 16'h0000, "or_r1");
    read_reg(3'd1, v);
    checks++;
    if (v !== 8'h0F) begin errors++; $display("FAIL or_r1 got %0h required 0f", v); end
  endtask

  task automatic test_mv();
    int nc, ns, nd;
    logic [7:0] w, a, b, p, v;
    run_instr(9'b000_011_011, 16'h0000, nc, ns, nd, w, a, b, p);
    read_reg(3'd3, v);
    checks++;
    if (v !== 8'h01) begin errors++; $display("FAIL mv_same got %0h required 1", v); end
    run_instr(9'b000_101_000, 16'h0000, nc, ns, nd, w, a, b, p);
    checks++;
    if (w !== 8'b0010_0000) begin errors++; $display("FAIL mv_reg_wr got %b required 00100000", w); end
    read_reg(3'd5, v);
    checks++;
    if (v !== 8'h0D) begin errors++; $display("FAIL mv_r5 got %0h required 0d", v); end
  endtask

  task automatic test_nop();
    int nc, ns, nd;
    logic [7:0] w, a, b, p, v;
    run_instr(9'b110_000_000, 16'h00AA, nc, ns, nd, w, a, b, p);
    checks++;
    if (nc !== 3 || ns !== 1 || nd !== 1) begin
      errors++; $display("FAIL nop_timing got cyc=%0d step=%0d done=%0d required 3/1/1", nc, ns, nd);
    end
    checks++;
    if (w !== 8'h00) begin errors++; $display("FAIL nop_reg_wr got %b required 0", w); end
    read_reg(3'd0, v);
    checks++;
    if (v !== 8'h0D) begin errors++; $display("FAIL nop_r0 got %0h required 0d", v); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    instruction = 9'b010_100_000; data_var = 16'h0011; run = 1'b1;
    repeat (3) tick();
    checks++;
    if (state_dbg !== S_WB || step !== 1'b1 || reg_wr !== 8'h10) begin
      errors++; $display("FAIL b2b_first_wb got st=%0d step=%b wr=%b required 4/1/00010000",
                         state_dbg, step, reg_wr);
    end
    instruction = 9'b010_101_000; data_var = 16'h0022;
    tick();
    read_reg(3'd4, v);
    checks++;
    if (state_dbg !== S_FETCH || v !== 8'h11) begin
      errors++; $display("FAIL b2b_refetch got st=%0d r4=%0h required 1/11", state_dbg, v);
    end
    tick();
    run = 1'b0;
    tick();
    checks++;
    if (reg_wr !== 8'h20) begin errors++; $display("FAIL b2b_second_wr got %b required 00100000", reg_wr); end
    tick();
    read_reg(3'd5, v);
    checks++;
    if (state_dbg !== S_IDLE || v !== 8'h22) begin
      errors++; $display("FAIL b2b_second got st=%0d r5=%0h required 0/22", state_dbg, v);
    end
  endtask

  task automatic test_run_drop();
    logic [7:0] v;
    int nstep;
    instruction = 9'b010_100_000; data_var = 16'h0007; run = 1'b1;
    tick();
    tick();
    run = 1'b0;
    tick();
    tick();
    read_reg(3'd4, v);
    checks++;
    if (v !== 8'h07) begin errors++; $display("FAIL run_drop_r4 got %0h required 7", v); end
    nstep = 0;
    for (int i = 0; i < 5; i++) begin
      if (step || state_dbg != S_IDLE) nstep++;
      tick();
    end
    checks++;
    if (nstep !== 0) begin errors++; $display("FAIL run_drop_idle got %0d active cycles required 0", nstep); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    instruction = 9'b011_000_001; data_var = 16'h0000; run = 1'b1;
    repeat (3) tick();
    checks++;
    if (state_dbg !== S_EXEC) begin errors++; $display("FAIL rmid_exec got %0d required 3", state_dbg); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({step, done, halted, reg_wr, alu_a, alu_b, alu_instr} !== '0 || state_dbg !== S_IDLE) begin
      errors++; $display("FAIL rmid_outputs got %0h st=%0d required 0/0",
                         {step, done, halted, reg_wr, alu_a, alu_b, alu_instr}, state_dbg);
    end
    run = 1'b0;
    tick();
    rst = 1'b1;
    repeat (3) tick();
    read_reg(3'd0, v);
    checks++;
    if (v !== 8'h00 || state_dbg !== S_IDLE) begin
      errors++; $display("FAIL rmid_r0 got %0h st=%0d required 0/0", v, state_dbg);
    end
  endtask

  task automatic test_halt();
    int nstep;
    instruction = 9'b111_000_000; data_var = 16'h0000; run = 1'b1;
    tick();
    tick();
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL halt_early got %b required 0", halted); end
    tick();
    checks++;
    if (halted !== 1'b1 || state_dbg !== S_HALT) begin
      errors++; $display("FAIL halt_enter got halted=%b st=%0d required 1/5", halted, state_dbg);
    end
    nstep = 0;
    for (int i = 0; i < 20; i++) begin
      if (step || reg_wr != 0 || !halted) nstep++;
      tick();
    end
    checks++;
    if (nstep !== 0) begin errors++; $display("FAIL halt_absorb got %0d bad cycles required 0", nstep); end
    run = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (halted !== 1'b0 || state_dbg !== S_IDLE) begin
      errors++; $display("FAIL halt_reset got halted=%b st=%0d required 0/0", halted, state_dbg);
    end
    rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_mvi();
    test_add();
    test_wrap();
    test_logic();
    test_mv();
    test_nop();
    test_back_to_back();
    test_run_drop();
    test_reset_mid();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
